// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam int CNT_W = 6;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's complement of a 2*W-bit value, either as one word
// (split=0, neg_hi selects) or as two independent W-bit halves (split=1).
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] value,
  input  logic           split,
  input  logic           neg_hi,
  input  logic           neg_lo,
  output logic [2*W-1:0] result
);

  logic [2*W-1:0] full_n;
  logic [W-1:0]   hi_n;
  logic [W-1:0]   lo_n;

  assign full_n = ~value + 1'b1;
  assign hi_n   = ~value[2*W-1:W] + 1'b1;
  assign lo_n   = ~value[W-1:0] + 1'b1;

  always_comb begin
    result = value;
    if (split) begin
      result = {(neg_hi ? hi_n : value[2*W-1:W]), (neg_lo ? lo_n : value[W-1:0])};
    end else if (neg_hi) begin
      result = full_n;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Optional macro MULDIV_EARLY_OUT_EN: multiply leaves RUN once remaining multiplier bits are zero.
//   state | meaning
//   IDLE  | waiting for start; MTHI/MTLO accepted
//   PREP  | operand magnitudes and result signs; divide-by-zero detect
//   RUN   | XLEN shift-add / restoring shift-subtract steps
//   FIX   | apply result signs, write HI/LO (skipped write on divide-by-zero)
//   DONE  | done pulse, then back to IDLE
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_e              state_q, state_d;
  op_e                 op_q;
  logic [XLEN-1:0]     a_q, b_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                sign_q, rsign_q, dbz_q;
  logic [XLEN-1:0]     hi_q, lo_q;

  logic                is_div, is_signed, zero_div, last_step, early_out;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_step, div_step;
  logic                div_ge;
  logic [XLEN-1:0]     div_diff;
  logic [2*XLEN-1:0]   neg_in, neg_res;
  logic                neg_split, neg_hi, neg_lo;

  assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
  assign zero_div  = is_div && (b_q == '0);
  assign last_step = (cnt_q == CNT_W'(XLEN - 1));

  // Multiply: LSB-first on the multiplier held in the low half of acc.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

  // Divide: the shifted partial remainder is acc[2X-1:X-1]; its subtraction fits in XLEN bits.
  assign div_ge   = acc_q[2*XLEN-1:XLEN-1] >= {1'b0, b_q};
  assign div_diff = acc_q[2*XLEN-2:XLEN-1] - b_q;
  assign div_step = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                           : {acc_q[2*XLEN-2:0], 1'b0};

`ifdef MULDIV_EARLY_OUT_EN
  logic [XLEN-1:0] rem_mask;
  assign rem_mask  = {XLEN{1'b1}} >> cnt_q;
  assign early_out = !is_div && ((acc_q[XLEN-1:0] & rem_mask) == '0);
`else
  assign early_out = 1'b0;
`endif

  always_comb begin
    neg_in    = acc_q;
    neg_split = is_div;
    neg_hi    = is_div ? rsign_q : sign_q;
    neg_lo    = sign_q;
    if (state_q == PREP) begin
      neg_in    = {a_q, b_q};
      neg_split = 1'b1;
      neg_hi    = is_signed & a_q[XLEN-1];
      neg_lo    = is_signed & b_q[XLEN-1];
    end
  end

  muldiv_negate #(.W(XLEN)) u_negate (
    .value  (neg_in),
    .split  (neg_split),
    .neg_hi (neg_hi),
    .neg_lo (neg_lo),
    .result (neg_res)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    done        = 1'b0;
    div_by_zero = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = PREP;
      PREP: begin
        busy    = 1'b1;
        state_d = zero_div ? FIX : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step || early_out) state_d = FIX;
      end
      FIX: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done        = 1'b1;
        div_by_zero = dbz_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      rsign_q <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            op_q <= op_e'(op);
            a_q  <= rs_val;
            b_q  <= rt_val;
          end
        end
        PREP: begin
          sign_q  <= is_signed & (a_q[XLEN-1] ^ b_q[XLEN-1]);
          rsign_q <= is_signed & a_q[XLEN-1];
          dbz_q   <= zero_div;
          cnt_q   <= '0;
          if (is_div) begin
            acc_q <= {{XLEN{1'b0}}, neg_res[2*XLEN-1:XLEN]};
            b_q   <= neg_res[XLEN-1:0];
          end else begin
            acc_q <= {{XLEN{1'b0}}, neg_res[XLEN-1:0]};
            b_q   <= neg_res[2*XLEN-1:XLEN];
          end
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (early_out) acc_q <= acc_q >> (XLEN - int'(cnt_q));
          else if (is_div) acc_q <= div_step;
          else acc_q <= mul_step;
        end
        FIX: begin
          if (!dbz_q) begin
            hi_q <= neg_res[2*XLEN-1:XLEN];
            lo_q <= neg_res[XLEN-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
